id_exe_stage: RTL and testbench
===============================

ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL: ID_Valid, input, 1, decode stage holds a real instruction.
REQ-004 SHALL: ID_Rs / ID_Rt / ID_Rd, input, 5 each, decoded register fields.
REQ-005 SHALL: ID_UsesRt, input, 1, instruction reads Rt as a source.
REQ-006 SHALL: ID_RegDst, input, 1, 1 = destination is Rd, 0 = Rt.
REQ-007 SHALL: ID_Ctrl, input, 7, {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[1:0]}.
REQ-008 SHALL: ID_ReadData1 / ID_ReadData2 / ID_Imm, input, 32 each, operands and sign-extended immediate.
REQ-009 SHALL: flush, input, 1, squash the decode instruction (branch taken / jump).
REQ-010 SHALL: ID_EXE_Rs / ID_EXE_Rt / ID_EXE_DstReg, output, 5 each, registered source and destination fields for the forwarding unit.
REQ-011 SHALL: ID_EXE_Ctrl, output, 7, registered control bundle, same bit order as ID_Ctrl.
REQ-012 SHALL: ID_EXE_ReadData1 / ID_EXE_ReadData2 / ID_EXE_Imm, output, 32 each, registered operands.
REQ-013 SHALL: stall, output, 1, combinational; freezes PC and IF/ID.

Function
REQ-014 SHALL: Compute the load-use hazard as ID_Valid && Ctrl.MemRead && DstReg!=0 && (DstReg==ID_Rs || (ID_UsesRt && DstReg==ID_Rt)), where Ctrl and DstReg are the registered ID_EXE_Ctrl.MemRead and ID_EXE_DstReg.
REQ-015 SHALL: Drive stall = hazard && !flush; flush has priority because the decode instruction is discarded.
REQ-016 SHALL: Load a bubble on each edge where flush || stall || !ID_Valid: all outputs zero.
REQ-017 SHALL: Otherwise load all ID_* fields, with DstReg = ID_RegDst ? ID_Rd : ID_Rt.
REQ-018 SHALL: Latency is exactly 1 cycle from ID inputs to ID_EXE_* outputs; no internal enable path holds old contents.
REQ-019 SHALL: Limit a load-use stall to exactly 1 cycle, since the inserted bubble clears MemRead. The following MEM_WB forwarding is not this block's concern.
REQ-020 SHALL: Never stall on a destination of register 0.
REQ-021 SHALL: Compare only Rs when ID_UsesRt=0, for I-type ALU instructions and loads.
REQ-022 SHALL: On simultaneous flush and hazard, insert one bubble with stall=0.

Reset
REQ-023 SHALL: While rst_n=0, asynchronously clear all registered outputs to 0; stall therefore reads 0.
REQ-024 SHALL: On the first rising edge after rst_n deasserts, perform a normal load; reset asserted mid-stall clears the pipeline register immediately.

Configuration
REQ-025 SHALL: With HAZARD_STATS_EN defined, add output stall_count[15:0]: reset to 0, +1 on each edge where stall=1, saturate at 16'hFFFF.
REQ-026 SHALL: Without HAZARD_STATS_EN, omit the stall_count port and counter logic entirely; all other behaviour is identical.

Verification
REQ-027 SHALL: Normal load. ID_Valid=1, Rs=2, Rt=3, Rd=4, RegDst=1, Ctrl=7'b1000010 -> next cycle ID_EXE_Rs=2, ID_EXE_Rt=3, ID_EXE_DstReg=4, ID_EXE_Ctrl=7'b1000010, stall=0.
REQ-028 SHALL: Load-use hazard. Register lw to $5 (Ctrl=7'b1101100, RegDst=0, Rt=5); next decode Rs=5 -> stall=1 for one cycle; bubble registered (ID_EXE_Ctrl=0); the instruction loads on the following edge.
REQ-029 SHALL: No false stall. lw to $0, then decode Rs=0 -> stall=0. lw to $5, then decode Rt=5 with ID_UsesRt=0 -> stall=0.
REQ-030 SHALL: Flush priority. Hazard condition true and flush=1 -> stall=0 and bubble registered.
REQ-031 SHALL: Async reset. Drop rst_n mid-cycle with outputs nonzero -> all outputs 0 before the next clk edge.
REQ-032 SHALL: HAZARD_STATS_EN. Three load-use stalls -> stall_count=3; with the counter preloaded to 16'hFFFF, a further stall leaves it at 16'hFFFF.

Source files
------------

// File: rtl/id_exe_stage_if.sv
// id_exe_stage_if: decode-side inputs and registered ID/EXE outputs of the ID/EXE pipeline register
// master: decode/hazard side (drives ID_* and flush, observes ID_EXE_* and stall)
// slave : the id_exe_stage pipeline register itself
interface id_exe_stage_if;
  logic        ID_Valid;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [4:0]  ID_Rd;
  logic        ID_UsesRt;
  logic        ID_RegDst;
  logic [6:0]  ID_Ctrl;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] ID_Imm;
  logic        flush;
  logic [4:0]  ID_EXE_Rs;
  logic [4:0]  ID_EXE_Rt;
  logic [4:0]  ID_EXE_DstReg;
  logic [6:0]  ID_EXE_Ctrl;
  logic [31:0] ID_EXE_ReadData1;
  logic [31:0] ID_EXE_ReadData2;
  logic [31:0] ID_EXE_Imm;
  logic        stall;
  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, ID_RegDst, ID_Ctrl,
           ID_ReadData1, ID_ReadData2, ID_Imm, flush,
    input  ID_EXE_Rs, ID_EXE_Rt, ID_EXE_DstReg, ID_EXE_Ctrl,
           ID_EXE_ReadData1, ID_EXE_ReadData2, ID_EXE_Imm, stall
  );
  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, ID_RegDst, ID_Ctrl,
           ID_ReadData1, ID_ReadData2, ID_Imm, flush,
    output ID_EXE_Rs, ID_EXE_Rt, ID_EXE_DstReg, ID_EXE_Ctrl,
           ID_EXE_ReadData1, ID_EXE_ReadData2, ID_EXE_Imm, stall
  );
endinterface

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EXE pipeline register with load-use hazard detection and flush
// Ports: clk, rst_n (async active-low), bus (id_exe_stage_if.slave),
//        stall_count[15:0] (only when HAZARD_STATS_EN is defined: saturating stall counter)
// ID_Ctrl bit order: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[1:0]}
module id_exe_stage (
  input logic clk,
  input logic rst_n,
  id_exe_stage_if.slave bus
`ifdef HAZARD_STATS_EN
  ,output logic [15:0] stall_count
`endif
);
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [6:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } pipe_t;
  pipe_t pipe_q, pipe_d;
  logic hazard, bubble;
  // ctrl[5] is MemRead of the instruction now in EXE; a load to $0 never hazards
  assign hazard = bus.ID_Valid && pipe_q.ctrl[5] && (pipe_q.dst != 5'd0) &&
                  ((pipe_q.dst == bus.ID_Rs) || (bus.ID_UsesRt && (pipe_q.dst == bus.ID_Rt)));
  // a flushed decode instruction is discarded anyway, so it never needs to stall
  assign bus.stall = hazard && !bus.flush;
  assign bubble = bus.flush || bus.stall || !bus.ID_Valid;
  always_comb begin
    pipe_d = '0;
    if (!bubble) begin
      pipe_d.rs   = bus.ID_Rs;
      pipe_d.rt   = bus.ID_Rt;
      pipe_d.dst  = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
      pipe_d.ctrl = bus.ID_Ctrl;
      pipe_d.rd1  = bus.ID_ReadData1;
      pipe_d.rd2  = bus.ID_ReadData2;
      pipe_d.imm  = bus.ID_Imm;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  assign bus.ID_EXE_Rs        = pipe_q.rs;
  assign bus.ID_EXE_Rt        = pipe_q.rt;
  assign bus.ID_EXE_DstReg    = pipe_q.dst;
  assign bus.ID_EXE_Ctrl      = pipe_q.ctrl;
  assign bus.ID_EXE_ReadData1 = pipe_q.rd1;
  assign bus.ID_EXE_ReadData2 = pipe_q.rd2;
  assign bus.ID_EXE_Imm       = pipe_q.imm;
`ifdef HAZARD_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (bus.stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: table-driven, hand-sequenced and randomized checks of id_exe_stage against a reference model
module tb_id_exe_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  id_exe_stage_if bus();
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
  id_exe_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_count(stall_count));
`else
  id_exe_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  localparam logic [6:0] LW  = 7'b1101100;
  localparam logic [6:0] ALU = 7'b1000010;
  int tests = 0;
  int fails = 0;
  // reference model: the instruction currently held in EXE (all zero = bubble)
  logic [4:0]  m_rs, m_rt, m_dst;
  logic [6:0]  m_ctrl;
  logic [31:0] m_d1, m_d2, m_imm;
  int          m_cnt;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  task automatic m_clear();
    {m_rs, m_rt, m_dst, m_ctrl, m_d1, m_d2, m_imm} = '0;
    m_cnt = 0;
  endtask
  function automatic logic m_stall();
    logic load_in_exe, uses_dst;
    load_in_exe = m_ctrl[5] && m_dst != 0;
    uses_dst = (m_dst == bus.ID_Rs) || (bus.ID_UsesRt && m_dst == bus.ID_Rt);
    return bus.ID_Valid && load_in_exe && uses_dst && !bus.flush;
  endfunction
  task automatic drive(input logic v, input logic [4:0] rs, rt, rd, input logic uses, regdst,
                       input logic [6:0] ctrl, input logic fl, input logic [31:0] d1, d2, imm);
    bus.ID_Valid = v; bus.ID_Rs = rs; bus.ID_Rt = rt; bus.ID_Rd = rd;
    bus.ID_UsesRt = uses; bus.ID_RegDst = regdst; bus.ID_Ctrl = ctrl; bus.flush = fl;
    bus.ID_ReadData1 = d1; bus.ID_ReadData2 = d2; bus.ID_Imm = imm;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".Rs"}, 32'(bus.ID_EXE_Rs), 32'(m_rs));
    chk({tag, ".Rt"}, 32'(bus.ID_EXE_Rt), 32'(m_rt));
    chk({tag, ".Dst"}, 32'(bus.ID_EXE_DstReg), 32'(m_dst));
    chk({tag, ".Ctrl"}, 32'(bus.ID_EXE_Ctrl), 32'(m_ctrl));
    chk({tag, ".RD1"}, bus.ID_EXE_ReadData1, m_d1);
    chk({tag, ".RD2"}, bus.ID_EXE_ReadData2, m_d2);
    chk({tag, ".Imm"}, bus.ID_EXE_Imm, m_imm);
`ifdef HAZARD_STATS_EN
    chk({tag, ".cnt"}, 32'(stall_count), 32'(m_cnt));
`endif
  endtask
  // checks stall before the edge, advances model and DUT one clock, checks registered outputs
  task automatic step(input string tag);
    logic s;
    #1;
    s = m_stall();
    chk({tag, ".stall"}, 32'(bus.stall), 32'(s));
    @(posedge clk);
    if (s && m_cnt < 65535) m_cnt++;
    if (!bus.ID_Valid || bus.flush || s) {m_rs, m_rt, m_dst, m_ctrl, m_d1, m_d2, m_imm} = '0;
    else begin
      m_rs = bus.ID_Rs; m_rt = bus.ID_Rt; m_dst = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
      m_ctrl = bus.ID_Ctrl; m_d1 = bus.ID_ReadData1; m_d2 = bus.ID_ReadData2; m_imm = bus.ID_Imm;
    end
    #1;
    check_outs(tag);
  endtask
  typedef struct {
    logic v; logic [4:0] rs, rt, rd; logic uses, regdst; logic [6:0] ctrl; logic fl;
    logic exp_stall; logic [6:0] exp_ctrl; logic [4:0] exp_dst;
  } vec_t;
  vec_t tbl[14];
  initial begin
    tbl[0]  = '{1, 2, 3, 4, 1, 1, ALU, 0, 0, ALU, 4};
    tbl[1]  = '{1, 1, 5, 0, 0, 0, LW,  0, 0, LW,  5};
    tbl[2]  = '{1, 5, 6, 7, 1, 1, ALU, 0, 1, 0,   0};
    tbl[3]  = '{1, 5, 6, 7, 1, 1, ALU, 0, 0, ALU, 7};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, LW,  0, 0, LW,  0};
    tbl[5]  = '{1, 0, 0, 8, 1, 1, ALU, 0, 0, ALU, 8};
    tbl[6]  = '{1, 1, 5, 0, 0, 0, LW,  0, 0, LW,  5};
    tbl[7]  = '{1, 1, 5, 9, 0, 1, ALU, 0, 0, ALU, 9};
    tbl[8]  = '{1, 1, 5, 0, 0, 0, LW,  0, 0, LW,  5};
    tbl[9]  = '{1, 5, 6, 7, 1, 1, ALU, 1, 0, 0,   0};
    tbl[10] = '{0, 3, 4, 5, 1, 1, ALU, 0, 0, 0,   0};
    tbl[11] = '{1, 2, 3, 6, 1, 1, LW,  0, 0, LW,  6};
    tbl[12] = '{1, 1, 6, 2, 1, 1, ALU, 0, 1, 0,   0};
    tbl[13] = '{1, 1, 6, 2, 1, 1, ALU, 0, 0, ALU, 2};
    rst_n = 1'b0;
    m_clear();
    drive(1, 9, 9, 9, 1, 1, ALU, 0, 32'h11, 32'h22, 32'h33);
    #12;
    check_outs("reset");
    chk("reset.stall", 32'(bus.stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // table: first row also covers the first load right after reset release
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].uses, tbl[i].regdst, tbl[i].ctrl,
            tbl[i].fl, 32'h1000 + i, 32'h2000 + i, 32'hFFFF_FF00 + i);
      #1;
      chk($sformatf("tbl%0d.stall", i), 32'(bus.stall), 32'(tbl[i].exp_stall));
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.ectrl", i), 32'(bus.ID_EXE_Ctrl), 32'(tbl[i].exp_ctrl));
      chk($sformatf("tbl%0d.edst", i), 32'(bus.ID_EXE_DstReg), 32'(tbl[i].exp_dst));
    end
    // async reset while a stall is in progress
    drive(1, 1, 5, 0, 0, 0, LW, 0, 32'hA, 32'hB, 32'hC);
    step("arst.lw");
    drive(1, 5, 2, 3, 1, 1, ALU, 0, 1, 2, 3);
    #2;
    chk("arst.pre_stall", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    m_clear();
    check_outs("arst");
    chk("arst.stall", 32'(bus.stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("arst.first");
    chk("arst.first.dst", 32'(bus.ID_EXE_DstReg), 3);
`ifdef HAZARD_STATS_EN
    rst_n = 1'b0;
    #1;
    m_clear();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 5, 0, 0, 0, LW, 0, 0, 0, 0);
      step("cnt.lw");
      drive(1, 5, 1, 2, 1, 1, ALU, 0, 0, 0, 0);
      step("cnt.stall");
      step("cnt.go");
    end
    chk("cnt.three", 32'(stall_count), 3);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 65535;
    drive(1, 1, 5, 0, 0, 0, LW, 0, 0, 0, 0);
    step("sat.lw");
    drive(1, 5, 1, 2, 1, 1, ALU, 0, 0, 0, 0);
    step("sat.stall");
    chk("cnt.sat", 32'(stall_count), 32'hFFFF);
`endif
    // randomized traffic over a small register range so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      logic [6:0] c;
      c = 7'($urandom);
      c[5] = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), c,
            $urandom_range(0, 9) == 0, $urandom, $urandom, $urandom);
      step($sformatf("rnd%0d", n));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
